rpn_wnn_to_network_bridge_arbiter: RTL and testbench

- Return-path counterpart of the RPN WNN from-network-bridge splitter.
- Merges the outgoing AXIS message streams of the RPN WNN repo and the RPN WNN node into the single to-network-bridge AXIS stream.
- Arbitration is round-robin and packet-atomic: once a source is granted, it keeps the grant until its tlast beat is accepted.
- Output is a one-deep register slice; the block also keeps a saturating forwarded-packet counter per source for debug.

---
 rtl/rpn_wnn_to_network_bridge_arbiter_if.sv | 29 ++
 rtl/rpn_wnn_to_network_bridge_arbiter.sv | 149 ++++++++++++++
 tb/tb_rpn_wnn_to_network_bridge_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_wnn_to_network_bridge_arbiter_if.sv
// AXI-Stream link used between the WNN sources,
// the return-path arbiter and the network bridge.
interface rpn_wnn_to_network_bridge_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 64
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [DEST_W-1:0] tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              tlast;

  modport master (
    output tvalid, tdata, tkeep, tid,
    output tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid,
    input  tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/rpn_wnn_to_network_bridge_arbiter.sv
// Packet-atomic round-robin merge of the WNN repo and node
// streams into the network bridge, with a one-deep output slot.
module rpn_wnn_to_network_bridge_arbiter #(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_TDEST_WIDTH = 8,
  parameter int AXIS_TUSER_WIDTH = 64,
  parameter int PKT_CNT_WIDTH    = 16
) (
  input  logic i_clk,
  input  logic i_ap_rst,
  rpn_wnn_to_network_bridge_arbiter_if.slave  from_rpn_wnn_repo,
  rpn_wnn_to_network_bridge_arbiter_if.slave  from_rpn_wnn_node,
  rpn_wnn_to_network_bridge_arbiter_if.master to_network_bridge,
  output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt_repo,
  output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt_node
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_REPO,
    LOCK_NODE
  } state_t;

  state_t state;
  logic   last_node;

  logic                        out_valid;
  logic [AXIS_DATA_WIDTH-1:0]  out_data;
  logic [AXIS_KEEP_WIDTH-1:0]  out_keep;
  logic [AXIS_TDEST_WIDTH-1:0] out_id;
  logic [AXIS_TDEST_WIDTH-1:0] out_dest;
  logic [AXIS_TUSER_WIDTH-1:0] out_user;
  logic                        out_last;

  logic slot_free;
  logic rdy_repo;
  logic rdy_node;
  logic acc_repo;
  logic acc_node;

  logic [AXIS_DATA_WIDTH-1:0]  sel_data;
  logic [AXIS_KEEP_WIDTH-1:0]  sel_keep;
  logic [AXIS_TDEST_WIDTH-1:0] sel_id;
  logic [AXIS_TDEST_WIDTH-1:0] sel_dest;
  logic [AXIS_TUSER_WIDTH-1:0] sel_user;
  logic                        sel_last;

  // In IDLE each ready looks only at the other source's
  // valid, so a tready never depends on its own tvalid.
  always_comb begin
    rdy_repo = 1'b0;
    rdy_node = 1'b0;
    unique case (1'b1)
      state == LOCK_REPO: rdy_repo = 1'b1;
      state == LOCK_NODE: rdy_node = 1'b1;
      state == IDLE: begin
        rdy_repo = !from_rpn_wnn_node.tvalid
                 || last_node;
        rdy_node = !from_rpn_wnn_repo.tvalid
                 || !last_node;
      end
    endcase
    slot_free = !out_valid || to_network_bridge.tready;
    rdy_repo  = rdy_repo && slot_free && !i_ap_rst;
    rdy_node  = rdy_node && slot_free && !i_ap_rst;
    acc_repo  = from_rpn_wnn_repo.tvalid && rdy_repo;
    acc_node  = from_rpn_wnn_node.tvalid && rdy_node;
  end

  always_comb begin
    sel_data = from_rpn_wnn_repo.tdata;
    sel_keep = from_rpn_wnn_repo.tkeep;
    sel_id   = from_rpn_wnn_repo.tid;
    sel_dest = from_rpn_wnn_repo.tdest;
    sel_user = from_rpn_wnn_repo.tuser;
    sel_last = from_rpn_wnn_repo.tlast;
    if (acc_node) begin
      sel_data = from_rpn_wnn_node.tdata;
      sel_keep = from_rpn_wnn_node.tkeep;
      sel_id   = from_rpn_wnn_node.tid;
      sel_dest = from_rpn_wnn_node.tdest;
      sel_user = from_rpn_wnn_node.tuser;
      sel_last = from_rpn_wnn_node.tlast;
    end
  end

  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state          <= IDLE;
      last_node      <= 1'b1;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_keep       <= '0;
      out_id         <= '0;
      out_dest       <= '0;
      out_user       <= '0;
      out_last       <= 1'b0;
      o_pkt_cnt_repo <= '0;
      o_pkt_cnt_node <= '0;
    end else begin
      if (acc_repo || acc_node) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_keep  <= sel_keep;
        out_id    <= sel_id;
        out_dest  <= sel_dest;
        out_user  <= sel_user;
        out_last  <= sel_last;
      end else if (to_network_bridge.tready) begin
        out_valid <= 1'b0;
      end
      if (acc_repo) begin
        if (sel_last) begin
          state     <= IDLE;
          last_node <= 1'b0;
          if (!(&o_pkt_cnt_repo))
            o_pkt_cnt_repo <= o_pkt_cnt_repo
                            + PKT_CNT_WIDTH'(1);
        end else begin
          state <= LOCK_REPO;
        end
      end
      if (acc_node) begin
        if (sel_last) begin
          state     <= IDLE;
          last_node <= 1'b1;
          if (!(&o_pkt_cnt_node))
            o_pkt_cnt_node <= o_pkt_cnt_node
                            + PKT_CNT_WIDTH'(1);
        end else begin
          state <= LOCK_NODE;
        end
      end
    end
  end

  assign from_rpn_wnn_repo.tready = rdy_repo;
  assign from_rpn_wnn_node.tready = rdy_node;

  assign to_network_bridge.tvalid = out_valid;
  assign to_network_bridge.tdata  = out_data;
  assign to_network_bridge.tkeep  = out_keep;
  assign to_network_bridge.tid    = out_id;
  assign to_network_bridge.tdest  = out_dest;
  assign to_network_bridge.tuser  = out_user;
  assign to_network_bridge.tlast  = out_last;

endmodule

// File: tb/tb_rpn_wnn_to_network_bridge_arbiter.sv
// Directed bench for the WNN to-network-bridge arbiter:
// ordering, locking, backpressure, saturation and reset.
module tb_rpn_wnn_to_network_bridge_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_wnn_to_network_bridge_arbiter_if repo_if ();
  rpn_wnn_to_network_bridge_arbiter_if node_if ();
  rpn_wnn_to_network_bridge_arbiter_if out_if ();
  rpn_wnn_to_network_bridge_arbiter_if s_repo ();
  rpn_wnn_to_network_bridge_arbiter_if s_node ();
  rpn_wnn_to_network_bridge_arbiter_if s_out ();

  logic [15:0] cnt_repo;
  logic [15:0] cnt_node;
  logic [2:0]  s_cnt_repo;
  logic [2:0]  s_cnt_node;

  rpn_wnn_to_network_bridge_arbiter u_dut (
    .i_clk             (clk),
    .i_ap_rst          (rst),
    .from_rpn_wnn_repo (repo_if),
    .from_rpn_wnn_node (node_if),
    .to_network_bridge (out_if),
    .o_pkt_cnt_repo    (cnt_repo),
    .o_pkt_cnt_node    (cnt_node)
  );

  // narrow counters so saturation is reachable quickly
  rpn_wnn_to_network_bridge_arbiter #(
    .PKT_CNT_WIDTH (3)
  ) u_sat (
    .i_clk             (clk),
    .i_ap_rst          (rst),
    .from_rpn_wnn_repo (s_repo),
    .from_rpn_wnn_node (s_node),
    .to_network_bridge (s_out),
    .o_pkt_cnt_repo    (s_cnt_repo),
    .o_pkt_cnt_node    (s_cnt_node)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        src;
    logic [63:0] data;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [7:0]  keep;
    logic [63:0] user;
    int          cyc;
  } obeat_t;

  beat_t  rq[$];
  beat_t  nq[$];
  acc_t   acc_q[$];
  obeat_t out_q[$];
  logic [63:0] exp[$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  bit leak_en = 1'b0;
  bit leak    = 1'b0;

  function automatic logic [7:0] f_id(logic [63:0] d);
    return d[7:0] ^ 8'h5a;
  endfunction
  function automatic logic [7:0] f_dest(logic [63:0] d);
    return d[15:8] + 8'd1;
  endfunction
  function automatic logic [7:0] f_keep(logic [63:0] d);
    return ~d[7:0];
  endfunction
  function automatic logic [63:0] f_user(logic [63:0] d);
    return {d[31:0], ~d[31:0]};
  endfunction

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // source drivers and output monitor
  initial begin
    bit r_fire;
    bit n_fire;
    forever begin
      @(negedge clk);
      r_fire = repo_if.tvalid && repo_if.tready;
      n_fire = node_if.tvalid && node_if.tready;
      if (r_fire)
        acc_q.push_back('{1'b0, repo_if.tdata, cyc});
      if (n_fire)
        acc_q.push_back('{1'b1, node_if.tdata, cyc});
      if (leak_en && repo_if.tvalid && node_if.tready)
        leak = 1'b1;
      if (out_if.tvalid && out_if.tready)
        out_q.push_back('{out_if.tdata, out_if.tlast,
                          out_if.tid, out_if.tdest,
                          out_if.tkeep, out_if.tuser, cyc});
      @(posedge clk);
      #1;
      if (r_fire && rq.size() > 0) void'(rq.pop_front());
      if (n_fire && nq.size() > 0) void'(nq.pop_front());
      repo_if.tvalid = rq.size() > 0;
      if (rq.size() > 0) begin
        repo_if.tdata = rq[0].data;
        repo_if.tlast = rq[0].last;
        repo_if.tid   = f_id(rq[0].data);
        repo_if.tdest = f_dest(rq[0].data);
        repo_if.tkeep = f_keep(rq[0].data);
        repo_if.tuser = f_user(rq[0].data);
      end
      node_if.tvalid = nq.size() > 0;
      if (nq.size() > 0) begin
        node_if.tdata = nq[0].data;
        node_if.tlast = nq[0].last;
        node_if.tid   = f_id(nq[0].data);
        node_if.tdest = f_dest(nq[0].data);
        node_if.tkeep = f_keep(nq[0].data);
        node_if.tuser = f_user(nq[0].data);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    rq.delete();
    nq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    out_q.delete();
  endtask

  task automatic wait_out(int n);
    for (int i = 0; i < 100 && out_q.size() < n; i++)
      @(negedge clk);
    @(negedge clk);
    check("wait_out", 64'(out_q.size() >= n), 64'd1);
  endtask

  task automatic check_seq(string tag, input logic [63:0] e[$],
                           input bit contig);
    check({tag, "_len"}, 64'(out_q.size()), 64'(e.size()));
    foreach (e[i]) begin
      if (i < out_q.size()) begin
        check({tag, "_data"}, out_q[i].data, e[i]);
        if (contig && i > 0)
          check({tag, "_gap"},
                64'(out_q[i].cyc - out_q[i-1].cyc), 64'd1);
      end
    end
  endtask

  initial begin
    repo_if.tvalid = 1'b0;
    repo_if.tdata  = '0;
    repo_if.tlast  = 1'b0;
    repo_if.tid    = '0;
    repo_if.tdest  = '0;
    repo_if.tkeep  = '0;
    repo_if.tuser  = '0;
    node_if.tvalid = 1'b0;
    node_if.tdata  = '0;
    node_if.tlast  = 1'b0;
    node_if.tid    = '0;
    node_if.tdest  = '0;
    node_if.tkeep  = '0;
    node_if.tuser  = '0;
    out_if.tready  = 1'b1;
    s_repo.tvalid  = 1'b0;
    s_repo.tdata   = '0;
    s_repo.tlast   = 1'b0;
    s_repo.tid     = '0;
    s_repo.tdest   = '0;
    s_repo.tkeep   = '0;
    s_repo.tuser   = '0;
    s_node.tvalid  = 1'b0;
    s_node.tdata   = '0;
    s_node.tlast   = 1'b0;
    s_node.tid     = '0;
    s_node.tdest   = '0;
    s_node.tkeep   = '0;
    s_node.tuser   = '0;
    s_out.tready   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_tdata", out_if.tdata, 64'd0);
    check("rst_rdy_repo", 64'(repo_if.tready), 64'd0);
    check("rst_rdy_node", 64'(node_if.tready), 64'd0);
    check("rst_cnt_repo", 64'(cnt_repo), 64'd0);
    check("rst_cnt_node", 64'(cnt_node), 64'd0);
    rst = 1'b0;

    // repo-only three-beat packet
    leak_en = 1'b1;
    leak    = 1'b0;
    @(negedge clk);
    rq.push_back('{64'h11, 1'b0});
    rq.push_back('{64'h22, 1'b0});
    rq.push_back('{64'h33, 1'b1});
    wait_out(3);
    exp = {64'h11, 64'h22, 64'h33};
    check_seq("t1", exp, 1'b1);
    check("t1_last", 64'({out_q[0].last, out_q[1].last,
                          out_q[2].last}), 64'b001);
    check("t1_lat", 64'(out_q[0].cyc - acc_q[0].cyc), 64'd1);
    check("t1_side", 64'({out_q[1].id, out_q[1].dest,
                          out_q[1].keep}),
          64'({f_id(64'h22), f_dest(64'h22),
               f_keep(64'h22)}));
    check("t1_user", out_q[1].user, f_user(64'h22));
    check("t1_cnt_repo", 64'(cnt_repo), 64'd1);
    check("t1_cnt_node", 64'(cnt_node), 64'd0);
    check("t1_node_rdy", 64'(leak), 64'd0);
    leak_en = 1'b0;

    // both sources valid from reset, single-beat packets
    do_reset();
    @(negedge clk);
    rq.push_back('{64'hA0, 1'b1});
    rq.push_back('{64'hA1, 1'b1});
    nq.push_back('{64'hB0, 1'b1});
    nq.push_back('{64'hB1, 1'b1});
    wait_out(4);
    exp = {64'hA0, 64'hB0, 64'hA1, 64'hB1};
    check_seq("t2", exp, 1'b1);
    check("t2_cnt_repo", 64'(cnt_repo), 64'd2);
    check("t2_cnt_node", 64'(cnt_node), 64'd2);

    // node request arrives while repo packet is locked
    acc_q.delete();
    out_q.delete();
    leak_en = 1'b1;
    leak    = 1'b0;
    rq.push_back('{64'hC0, 1'b0});
    rq.push_back('{64'hC1, 1'b0});
    rq.push_back('{64'hC2, 1'b0});
    rq.push_back('{64'hC3, 1'b1});
    for (int i = 0; i < 20 && acc_q.size() < 1; i++)
      @(negedge clk);
    nq.push_back('{64'hD0, 1'b1});
    wait_out(5);
    exp = {64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'hD0};
    check_seq("t3", exp, 1'b1);
    check("t3_node_src", 64'(acc_q[4].src), 64'd1);
    check("t3_node_cyc", 64'(acc_q[4].cyc - acc_q[3].cyc),
          64'd1);
    check("t3_node_rdy", 64'(leak), 64'd0);
    check("t3_cnt_repo", 64'(cnt_repo), 64'd3);
    check("t3_cnt_node", 64'(cnt_node), 64'd3);
    leak_en = 1'b0;

    // downstream backpressure
    acc_q.delete();
    out_q.delete();
    @(posedge clk);
    #1;
    out_if.tready = 1'b0;
    @(negedge clk);
    rq.push_back('{64'hE0, 1'b0});
    rq.push_back('{64'hE1, 1'b0});
    rq.push_back('{64'hE2, 1'b1});
    for (int i = 0; i < 20 && !out_if.tvalid; i++)
      @(negedge clk);
    check("t4_valid", 64'(out_if.tvalid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", out_if.tdata, 64'hE0);
      check("t4_stall", 64'(repo_if.tready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_if.tready = 1'b1;
    @(negedge clk);
    check("t4_resume", 64'(repo_if.tready), 64'd1);
    wait_out(3);
    repeat (3) @(negedge clk);
    exp = {64'hE0, 64'hE1, 64'hE2};
    check_seq("t4", exp, 1'b0);

    // counter saturation on the narrow instance
    @(posedge clk);
    #1;
    s_out.tready  = 1'b1;
    s_repo.tdata  = 64'h5;
    s_repo.tlast  = 1'b1;
    s_repo.tvalid = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_sat_repo", 64'(s_cnt_repo), 64'd7);
    check("t5_sat_node", 64'(s_cnt_node), 64'd0);
    s_repo.tvalid = 1'b0;

    // asynchronous reset in the middle of a node packet
    do_reset();
    @(negedge clk);
    nq.push_back('{64'hF0, 1'b0});
    nq.push_back('{64'hF1, 1'b0});
    nq.push_back('{64'hF2, 1'b0});
    nq.push_back('{64'hF3, 1'b1});
    for (int i = 0; i < 20 && out_q.size() < 2; i++)
      @(negedge clk);
    check("t6_mid", 64'(out_if.tvalid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_tvalid", 64'(out_if.tvalid), 64'd0);
    check("t6_rdy_node", 64'(node_if.tready), 64'd0);
    check("t6_rdy_repo", 64'(repo_if.tready), 64'd0);
    check("t6_cnt_node", 64'(cnt_node), 64'd0);
    nq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    out_q.delete();
    @(negedge clk);
    rq.push_back('{64'h71, 1'b1});
    nq.push_back('{64'h81, 1'b1});
    wait_out(2);
    exp = {64'h71, 64'h81};
    check_seq("t6", exp, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
